// File: rtl/cache_edc_scrubber.sv
// Background SECDED scrubber for the data cache arrays: walks every word, rewrites
// corrected data/check bits on single errors and reports double errors.
module cache_edc_scrubber #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned INTERVAL = 256,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cache_busy,
    input  logic              cache_we,
    input  logic [ADDR_W-1:0] cache_waddr,
    output logic              scrub_re,
    output logic [ADDR_W-1:0] scrub_addr,
    input  logic [31:0]       mem_dout,
    input  logic [6:0]        mem_pout,
    output logic              scrub_dwe,
    output logic              scrub_pwe,
    output logic [31:0]       scrub_din,
    output logic [6:0]        scrub_pin,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic              ded_irq,
    output logic [ADDR_W-1:0] ded_addr,
    output logic              pass_done
);
    localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    typedef enum logic [2:0] {StIdle, StWait, StRd, StDec, StChk, StWr, StNext} state_e;

    // Data bits occupy the non-power-of-two positions 3..38 in ascending order.
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [6:0] p;
        logic [4:0] k;
        p = '0;
        k = '0;
        for (int unsigned pos = 3; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int unsigned i = 0; i < 6; i++) begin
                    if (pos[i]) p[i] = p[i] ^ d[k];
                end
                k = k + 5'd1;
            end
        end
        p[6] = ^{d, p[5:0]};
        return p;
    endfunction

    function automatic logic [31:0] flip_at(input logic [31:0] d, input logic [5:0] s);
        logic [31:0] r;
        logic [4:0]  k;
        r = d;
        k = '0;
        for (int unsigned pos = 3; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (pos[5:0] == s) r[k] = ~r[k];
                k = k + 5'd1;
            end
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ded_addr_q, ded_addr_d;
    logic [IW-1:0]     ivl_q, ivl_d;
    logic [31:0]       data_q, data_d, corr_q, corr_d;
    logic [6:0]        chk_q, chk_d, cpin_q, cpin_d;
    logic              snoop_q, snoop_d, ded_irq_q, ded_irq_d, pass_q, pass_d;
    logic [CNT_W-1:0]  sec_q, sec_d, ded_q, ded_d;

    logic [6:0]  synx;
    logic [5:0]  syn;
    logic        ovr, is_pow2, dec_ded, dec_sec, snoop_hit, wr_go;
    logic [31:0] corr;

    // ^synx equals the overall parity of the 39 stored bits.
    always_comb begin
        synx    = enc(data_q) ^ chk_q;
        syn     = synx[5:0];
        ovr     = ^synx;
        is_pow2 = (syn & (syn - 6'd1)) == 6'd0;
        dec_ded = ovr ? (syn > 6'd38) : (syn != 6'd0);
        dec_sec = ovr && !dec_ded;
        corr    = (dec_sec && !is_pow2) ? flip_at(data_q, syn) : data_q;
    end

    assign snoop_hit  = cache_we && (cache_waddr == addr_q);
    assign wr_go      = (state_q == StWr) && !cache_busy && !snoop_q && !snoop_hit;
    assign scrub_re   = (state_q == StRd) && !cache_busy;
    assign scrub_dwe  = wr_go;
    assign scrub_pwe  = wr_go;
    assign scrub_din  = wr_go ? corr_q : 32'd0;
    assign scrub_pin  = wr_go ? cpin_q : 7'd0;
    assign scrub_addr = addr_q;
    assign sec_cnt    = sec_q;
    assign ded_cnt    = ded_q;
    assign ded_irq    = ded_irq_q;
    assign ded_addr   = ded_addr_q;
    assign pass_done  = pass_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ivl_d      = ivl_q;
        data_d     = data_q;
        chk_d      = chk_q;
        corr_d     = corr_q;
        cpin_d     = cpin_q;
        snoop_d    = snoop_q;
        sec_d      = sec_q;
        ded_d      = ded_q;
        ded_addr_d = ded_addr_q;
        ded_irq_d  = 1'b0;
        pass_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ivl_d = '0;
                if (enable) state_d = StWait;
            end
            StWait: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (ivl_q == IW'(INTERVAL - 1)) begin
                    ivl_d   = '0;
                    state_d = StRd;
                end else begin
                    ivl_d = ivl_q + IW'(1);
                end
            end
            StRd: begin
                snoop_d = 1'b0;
                if (!cache_busy) state_d = StDec;
            end
            StDec: begin
                data_d  = mem_dout;
                chk_d   = mem_pout;
                snoop_d = snoop_hit;
                state_d = StChk;
            end
            StChk: begin
                corr_d  = corr;
                cpin_d  = enc(corr);
                state_d = StNext;
                if (snoop_q || snoop_hit) begin
                    snoop_d = 1'b1;
                end else if (dec_ded) begin
                    if (ded_q != '1) ded_d = ded_q + CNT_W'(1);
                    ded_irq_d  = 1'b1;
                    ded_addr_d = addr_q;
                end else if (dec_sec) begin
                    state_d = StWr;
                end
            end
            StWr: begin
                // A pipeline write to this word makes our copy stale: drop the repair.
                if (snoop_q || snoop_hit) begin
                    state_d = StNext;
                end else if (!cache_busy) begin
                    if (sec_q != '1) sec_d = sec_q + CNT_W'(1);
                    state_d = StNext;
                end
            end
            StNext: begin
                addr_d  = addr_q + ADDR_W'(1);
                pass_d  = (addr_q == '1);
                ivl_d   = '0;
                state_d = enable ? StWait : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            ivl_q      <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            corr_q     <= '0;
            cpin_q     <= '0;
            snoop_q    <= 1'b0;
            sec_q      <= '0;
            ded_q      <= '0;
            ded_addr_q <= '0;
            ded_irq_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ivl_q      <= ivl_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            corr_q     <= corr_d;
            cpin_q     <= cpin_d;
            snoop_q    <= snoop_d;
            sec_q      <= sec_d;
            ded_q      <= ded_d;
            ded_addr_q <= ded_addr_d;
            ded_irq_q  <= ded_irq_d;
            pass_q     <= pass_d;
        end
    end

endmodule

// File: tb/tb_cache_edc_scrubber.sv
// Directed bench for cache_edc_scrubber: small array, one-cycle interval, 2-bit counters,
// with a behavioural SECDED memory that the scrubber reads and repairs.
module tb_cache_edc_scrubber;
    localparam int unsigned AW    = 3;
    localparam int unsigned IV    = 1;
    localparam int unsigned CW    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          cache_busy = 1'b0;
    logic          cache_we = 1'b0;
    logic [AW-1:0] cache_waddr = '0;
    logic          scrub_re, scrub_dwe, scrub_pwe, ded_irq, pass_done;
    logic [AW-1:0] scrub_addr, ded_addr;
    logic [31:0]   mem_dout, scrub_din;
    logic [6:0]    mem_pout, scrub_pin;
    logic [CW-1:0] sec_cnt, ded_cnt;

    cache_edc_scrubber #(.ADDR_W(AW), .INTERVAL(IV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cache_busy(cache_busy),
        .cache_we(cache_we), .cache_waddr(cache_waddr), .scrub_re(scrub_re),
        .scrub_addr(scrub_addr), .mem_dout(mem_dout), .mem_pout(mem_pout),
        .scrub_dwe(scrub_dwe), .scrub_pwe(scrub_pwe), .scrub_din(scrub_din),
        .scrub_pin(scrub_pin), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_irq(ded_irq),
        .ded_addr(ded_addr), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_d [DEPTH];
    logic [6:0]  mem_p [DEPTH];
    logic [31:0] pre_d [DEPTH];
    logic [6:0]  pre_p [DEPTH];
    logic        load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] <= pre_d[i];
                mem_p[i] <= pre_p[i];
            end
        end else begin
            if (scrub_dwe) mem_d[scrub_addr] <= scrub_din;
            if (scrub_pwe) mem_p[scrub_addr] <= scrub_pin;
        end
        if (scrub_re) begin
            mem_dout <= mem_d[scrub_addr];
            mem_pout <= mem_p[scrub_addr];
        end
    end

    int          cyc = 0;
    int          re_n = 0;
    int          wr_n = 0;
    int          pass_n = 0;
    int          re_cyc [DEPTH];
    logic        wr_seen [DEPTH];
    logic        ded_seen [DEPTH];
    logic [31:0] wr_d [DEPTH];
    logic [6:0]  wr_p [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr_seen[i]  <= 1'b0;
                ded_seen[i] <= 1'b0;
            end
        end
        if (scrub_re) begin
            re_n               <= re_n + 1;
            re_cyc[scrub_addr] <= cyc;
        end
        if (scrub_dwe) begin
            wr_n                <= wr_n + 1;
            wr_seen[scrub_addr] <= 1'b1;
            wr_d[scrub_addr]    <= scrub_din;
            wr_p[scrub_addr]    <= scrub_pin;
        end
        if (ded_irq) ded_seen[ded_addr] <= 1'b1;
        if (pass_done) pass_n <= pass_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_re(input logic [AW-1:0] a, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (scrub_re && scrub_addr == a) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [6:0]  p;
        logic        wr;
        logic [31:0] wd;
        logic [6:0]  wp;
        logic        ded;
    } vec_t;

    vec_t vecs [DEPTH];

    initial begin
        int   n0, w0, r0;
        logic ok;

        vecs[0] = '{32'h0,  7'b0000000, 1'b0, 32'h0,  7'b0000000, 1'b0};
        vecs[1] = '{32'h0,  7'b1000011, 1'b1, 32'h1,  7'b1000011, 1'b0};
        vecs[2] = '{32'h3,  7'b0000000, 1'b0, 32'h0,  7'b0000000, 1'b1};
        vecs[3] = '{32'h0,  7'b1000000, 1'b1, 32'h0,  7'b0000000, 1'b0};
        vecs[4] = '{32'h0,  7'b0000001, 1'b1, 32'h0,  7'b0000000, 1'b0};
        vecs[5] = '{32'h1,  7'b1000011, 1'b0, 32'h0,  7'b0000000, 1'b0};
        vecs[6] = '{32'h11, 7'b1001001, 1'b1, 32'h10, 7'b1001001, 1'b0};
        vecs[7] = '{32'h0,  7'b1100111, 1'b0, 32'h0,  7'b0000000, 1'b1};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ctrl", {scrub_re, scrub_dwe, scrub_pwe, ded_irq, pass_done}, 0);
        check("reset_data", {scrub_din, scrub_pin, sec_cnt, ded_cnt}, 0);
        check("reset_addr", {scrub_addr, ded_addr}, 0);

        // Full pass over a table of clean, single-error and double-error words.
        for (int i = 0; i < DEPTH; i++) begin
            pre_d[i] = vecs[i].d;
            pre_p[i] = vecs[i].p;
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        enable = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (pass_done) ok = 1'b1;
        end
        check("pass_done_seen", ok, 1);
        enable = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("wr_seen[%0d]", i), wr_seen[i], vecs[i].wr);
            if (vecs[i].wr) begin
                check($sformatf("wr_data[%0d]", i), {wr_d[i], wr_p[i]}, {vecs[i].wd, vecs[i].wp});
            end
            check($sformatf("ded_seen[%0d]", i), ded_seen[i], vecs[i].ded);
            check($sformatf("mem_after[%0d]", i), {mem_d[i], mem_p[i]},
                  vecs[i].wr ? {vecs[i].wd, vecs[i].wp} : {vecs[i].d, vecs[i].p});
        end
        check("sec_cnt_saturated", sec_cnt, 3);
        check("ded_cnt", ded_cnt, 2);
        check("ded_addr", ded_addr, 7);
        check("addr_wrapped", scrub_addr, 0);
        check("pass_count", pass_n, 1);
        check("reads_per_pass", re_n, DEPTH);
        check("latency_clean", re_cyc[1] - re_cyc[0], IV + 4);
        check("latency_writeback", re_cyc[2] - re_cyc[1], IV + 5);

        // Busy stall, then a pipeline write to the word being decoded, with enable dropped.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pre_d[i] = '0;
            pre_p[i] = '0;
        end
        pre_p[1] = 7'b1000011;
        load = 1'b1;
        tick();
        load = 1'b0;
        cache_busy = 1'b1;
        enable = 1'b1;
        n0 = re_n;
        w0 = wr_n;
        repeat (50) tick();
        check("busy_no_read", re_n - n0, 0);
        r0 = re_n;
        cache_busy = 1'b0;
        wait_re(0, ok);
        check("read_after_release", ok, 1);
        wait_re(1, ok);
        check("read_addr1", ok, 1);
        tick();
        cache_we = 1'b1;
        cache_waddr = 3'd1;
        enable = 1'b0;
        tick();
        cache_we = 1'b0;
        repeat (20) tick();
        check("snoop_no_write", wr_n - w0, 0);
        check("snoop_mem_kept", {mem_d[1], mem_p[1]}, {32'h0, 7'b1000011});
        check("snoop_counters", {sec_cnt, ded_cnt}, 0);
        check("parked_addr", scrub_addr, 2);
        check("parked_reads", re_n - r0, 2);

        // Reset while a write-back is stalled by cache_busy must cancel it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pre_p[1] = 7'b0000000;
        pre_p[2] = 7'b0000001;
        load = 1'b1;
        tick();
        load = 1'b0;
        w0 = wr_n;
        enable = 1'b1;
        wait_re(2, ok);
        check("read_addr2", ok, 1);
        tick();
        cache_busy = 1'b1;
        repeat (4) tick();
        check("stalled_no_write", scrub_dwe, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        cache_busy = 1'b0;
        repeat (5) tick();
        check("rst_abort_no_write", wr_n - w0, 0);
        check("rst_abort_mem", mem_p[2], 7'b0000001);
        check("rst_abort_state", {sec_cnt, scrub_addr, scrub_re}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
